// File: rtl/elevator_controller.sv
// Three-floor elevator sequencing FSM with SCAN-order scheduling.
// Travel and door dwell are timed in cycles of the divided clock.
// Optional build macro: SOS_LATCH_EN makes the emergency sticky until reset.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | parked at current_floor, door closed, picks the next move
// MOVE_UP   | travelling one floor up; repeats while requests lie above
// MOVE_DOWN | travelling one floor down; repeats while requests lie below
// DOOR_OPEN | dwelling at a stop; held open while the cabin is overweight
// EMERGENCY | SOS active: motion stopped, requests flushed, buttons ignored
module elevator_controller #(
    parameter int TRAVEL_TICKS = 3,
    parameter int DOOR_TICKS   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sos_button,
    input  logic       weight_sensor,
    input  logic       st_floor_button,
    input  logic       nd_floor_button,
    input  logic       rd_floor_button,
    output logic       st_floor_led,
    output logic       nd_floor_led,
    output logic       rd_floor_led,
    output logic       sos_led,
    output logic       weight_led,
    output logic       emergency_led,
    output logic [1:0] current_floor,
    output logic       door_open,
    output logic       moving_up,
    output logic       moving_down
);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN,
        EMERGENCY
    } state_t;

    localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_TICKS - 1);

    state_t          state, state_n;
    logic [1:0]      floor, floor_n;
    logic [2:0]      req, req_n;
    logic [TW-1:0]   timer, timer_n;
    logic            last_dir, last_dir_n;   // 1 = up
    logic            sos_q, weight_q;
    logic [2:0]      buttons, pend, pend_door;

    function automatic logic [2:0] floor_bit(input logic [1:0] f);
        case (f)
            2'd0:    floor_bit = 3'b001;
            2'd1:    floor_bit = 3'b010;
            2'd2:    floor_bit = 3'b100;
            default: floor_bit = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] above_mask(input logic [1:0] f);
        case (f)
            2'd0:    above_mask = 3'b110;
            2'd1:    above_mask = 3'b100;
            default: above_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] below_mask(input logic [1:0] f);
        case (f)
            2'd1:    below_mask = 3'b001;
            2'd2:    below_mask = 3'b011;
            default: below_mask = 3'b000;
        endcase
    endfunction

    // Stop here if asked, otherwise head toward outstanding work; when work
    // lies on both sides keep going the way we last travelled.
    function automatic state_t schedule(input logic [2:0] p, input logic [1:0] f,
                                        input logic dir_up);
        logic up_any, dn_any;
        up_any = |(p & above_mask(f));
        dn_any = |(p & below_mask(f));
        if (|(p & floor_bit(f)))     schedule = DOOR_OPEN;
        else if (up_any && dn_any)   schedule = dir_up ? MOVE_UP : MOVE_DOWN;
        else if (up_any)             schedule = MOVE_UP;
        else if (dn_any)             schedule = MOVE_DOWN;
        else                         schedule = IDLE;
    endfunction

    assign buttons   = {rd_floor_button, nd_floor_button, st_floor_button};
    assign pend      = req | buttons;
    // A press at the floor whose door is already open is absorbed, not re-served.
    assign pend_door = pend & ~floor_bit(floor);

    // Next-state, position, timer and request bookkeeping.
    always_comb begin
        state_n    = state;
        floor_n    = floor;
        req_n      = req;
        timer_n    = timer;
        last_dir_n = last_dir;
        if (sos_button) begin
            state_n = EMERGENCY;
            timer_n = '0;
            req_n   = 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    req_n   = pend;
                    timer_n = '0;
                    state_n = schedule(pend, floor, last_dir);
                end
                MOVE_UP: begin
                    req_n = pend;
                    if (timer == TRAVEL_LAST) begin
                        floor_n    = (floor == 2'd2) ? floor : floor + 2'd1;
                        timer_n    = '0;
                        last_dir_n = 1'b1;
                        if (|(pend & floor_bit(floor_n)))       state_n = DOOR_OPEN;
                        else if (|(pend & above_mask(floor_n))) state_n = MOVE_UP;
                        else                                    state_n = IDLE;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
                MOVE_DOWN: begin
                    req_n = pend;
                    if (timer == TRAVEL_LAST) begin
                        floor_n    = (floor == 2'd0) ? floor : floor - 2'd1;
                        timer_n    = '0;
                        last_dir_n = 1'b0;
                        if (|(pend & floor_bit(floor_n)))       state_n = DOOR_OPEN;
                        else if (|(pend & below_mask(floor_n))) state_n = MOVE_DOWN;
                        else                                    state_n = IDLE;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
                DOOR_OPEN: begin
                    req_n = pend_door;
                    if (timer == DOOR_LAST) begin
                        timer_n = '0;
                        if (!weight_sensor)
                            state_n = schedule(pend_door, floor, last_dir);
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
                EMERGENCY: begin
                    req_n   = 3'b000;
                    timer_n = '0;
`ifdef SOS_LATCH_EN
                    state_n = EMERGENCY;
`else
                    state_n = IDLE;
`endif
                end
                default: begin
                    state_n = IDLE;
                    timer_n = '0;
                end
            endcase
        end
        if (state_n == DOOR_OPEN)
            req_n = req_n & ~floor_bit(floor_n);
    end

    // State, position, timer and request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            floor    <= 2'd0;
            req      <= 3'b000;
            timer    <= '0;
            last_dir <= 1'b1;
        end else begin
            state    <= state_n;
            floor    <= floor_n;
            req      <= req_n;
            timer    <= timer_n;
            last_dir <= last_dir_n;
        end
    end

    // Registered copies of the SOS and weight inputs for the indicator LEDs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sos_q    <= 1'b0;
            weight_q <= 1'b0;
        end else begin
`ifdef SOS_LATCH_EN
            sos_q    <= sos_q | sos_button;
`else
            sos_q    <= sos_button;
`endif
            weight_q <= weight_sensor;
        end
    end

    assign st_floor_led  = req[0];
    assign nd_floor_led  = req[1];
    assign rd_floor_led  = req[2];
    assign sos_led       = sos_q;
    assign weight_led    = weight_q;
    assign emergency_led = (state == EMERGENCY);
    assign current_floor = floor;
    assign door_open     = (state == DOOR_OPEN);
    assign moving_up     = (state == MOVE_UP);
    assign moving_down   = (state == MOVE_DOWN);

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller with TRAVEL_TICKS=3, DOOR_TICKS=2.
module tb_elevator_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sos_button = 1'b0, weight_sensor = 1'b0;
    logic       st_floor_button = 1'b0, nd_floor_button = 1'b0, rd_floor_button = 1'b0;
    logic       st_floor_led, nd_floor_led, rd_floor_led;
    logic       sos_led, weight_led, emergency_led;
    logic [1:0] current_floor;
    logic       door_open, moving_up, moving_down;
    logic [10:0] outs;

    int total = 0;
    int bad   = 0;

    // input vector: {sos, weight, st, nd, rd}
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] RD   = 5'b00001;
    localparam logic [4:0] ND   = 5'b00010;
    localparam logic [4:0] ST   = 5'b00100;
    localparam logic [4:0] WT   = 5'b01000;
    localparam logic [4:0] SOS  = 5'b10000;

    typedef struct {
        logic [4:0]  in;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[14];

    elevator_controller #(.TRAVEL_TICKS(3), .DOOR_TICKS(2)) dut (
        .clk(clk), .reset(reset),
        .sos_button(sos_button), .weight_sensor(weight_sensor),
        .st_floor_button(st_floor_button), .nd_floor_button(nd_floor_button),
        .rd_floor_button(rd_floor_button),
        .st_floor_led(st_floor_led), .nd_floor_led(nd_floor_led), .rd_floor_led(rd_floor_led),
        .sos_led(sos_led), .weight_led(weight_led), .emergency_led(emergency_led),
        .current_floor(current_floor), .door_open(door_open),
        .moving_up(moving_up), .moving_down(moving_down)
    );

    always #5 clk = ~clk;

    assign outs = {st_floor_led, nd_floor_led, rd_floor_led, sos_led, weight_led,
                   emergency_led, current_floor, door_open, moving_up, moving_down};

    // leds = {st,nd,rd}, swe = {sos_led,weight_led,emergency_led}, dud = {door,up,down}
    function automatic logic [10:0] o(input logic [2:0] leds, input logic [2:0] swe,
                                      input logic [1:0] fl, input logic [2:0] dud);
        o = {leds, swe, fl, dud};
    endfunction

    task automatic tick(input logic [4:0] in);
        {sos_button, weight_sensor, st_floor_button, nd_floor_button, rd_floor_button} = in;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [10:0] exp);
        total++;
        if (outs !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (leds,sos,wt,emg,floor,door,up,dn)",
                     name, outs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick(NONE);
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        tick(NONE);
        check(name, o(3'b000, 3'b000, 2'd0, 3'b000));
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{ST,   o(3'b000, 3'b000, 2'd0, 3'b100), "t2_st_door"};
        vecs[1]  = '{NONE, o(3'b000, 3'b000, 2'd0, 3'b100), "t2_door_dwell"};
        vecs[2]  = '{NONE, o(3'b000, 3'b000, 2'd0, 3'b000), "t2_door_close"};
        vecs[3]  = '{RD,   o(3'b001, 3'b000, 2'd0, 3'b010), "t1_rd_up"};
        vecs[4]  = '{NONE, o(3'b001, 3'b000, 2'd0, 3'b010), "t1_tick1"};
        vecs[5]  = '{NONE, o(3'b001, 3'b000, 2'd0, 3'b010), "t1_tick2"};
        vecs[6]  = '{NONE, o(3'b001, 3'b000, 2'd1, 3'b010), "t1_floor1"};
        vecs[7]  = '{NONE, o(3'b001, 3'b000, 2'd1, 3'b010), "t1_f1_tick1"};
        vecs[8]  = '{NONE, o(3'b001, 3'b000, 2'd1, 3'b010), "t1_f1_tick2"};
        vecs[9]  = '{NONE, o(3'b000, 3'b000, 2'd2, 3'b100), "t1_floor2_door"};
        vecs[10] = '{NONE, o(3'b000, 3'b000, 2'd2, 3'b100), "t1_door_dwell"};
        vecs[11] = '{NONE, o(3'b000, 3'b000, 2'd2, 3'b000), "t1_idle"};
        vecs[12] = '{WT,   o(3'b000, 3'b010, 2'd2, 3'b000), "weight_led_on"};
        vecs[13] = '{NONE, o(3'b000, 3'b000, 2'd2, 3'b000), "weight_led_off"};

        tick(NONE);
        do_reset("reset_state");
        for (int i = 0; i < 14; i++) begin
            tick(vecs[i].in);
            check(vecs[i].name, vecs[i].exp);
        end

        // reset during downward travel snaps back to floor 0 with nothing pending
        tick(ST);
        check("rm_down_start", o(3'b100, 3'b000, 2'd2, 3'b001));
        ticks(3);
        check("rm_floor1", o(3'b100, 3'b000, 2'd1, 3'b001));
        tick(NONE);
        do_reset("rm_reset_mid_travel");
        tick(NONE);
        check("rm_idle_after", o(3'b000, 3'b000, 2'd0, 3'b000));

        // test 3: intermediate stop picked up during travel
        tick(RD);
        check("t3_up", o(3'b001, 3'b000, 2'd0, 3'b010));
        tick(ND);
        check("t3_nd_latch", o(3'b011, 3'b000, 2'd0, 3'b010));
        tick(NONE);
        check("t3_tick2", o(3'b011, 3'b000, 2'd0, 3'b010));
        tick(NONE);
        check("t3_stop_f1", o(3'b001, 3'b000, 2'd1, 3'b100));
        tick(NONE);
        check("t3_dwell", o(3'b001, 3'b000, 2'd1, 3'b100));
        tick(NONE);
        check("t3_resume", o(3'b001, 3'b000, 2'd1, 3'b010));
        ticks(2);
        check("t3_still_up", o(3'b001, 3'b000, 2'd1, 3'b010));
        tick(NONE);
        check("t3_arrive_f2", o(3'b000, 3'b000, 2'd2, 3'b100));
        ticks(2);
        check("t3_idle_f2", o(3'b000, 3'b000, 2'd2, 3'b000));

        // test 4: overweight hold at floor 1 with floor 2 pending
        tick(ND);
        check("t4_down", o(3'b010, 3'b000, 2'd2, 3'b001));
        ticks(3);
        check("t4_door_f1", o(3'b000, 3'b000, 2'd1, 3'b100));
        tick(WT | RD);
        check("t4_rd_wt", o(3'b001, 3'b010, 2'd1, 3'b100));
        for (int i = 0; i < 12; i++) begin
            tick(WT);
            check($sformatf("t4_hold_%0d", i), o(3'b001, 3'b010, 2'd1, 3'b100));
        end
        tick(NONE);
        check("t4_release_up", o(3'b001, 3'b000, 2'd1, 3'b010));

        // test 5: SOS mid-travel between floors 1 and 2
        tick(SOS);
        check("t5_emergency", o(3'b000, 3'b101, 2'd1, 3'b000));
        tick(SOS | ST | ND);
        check("t5_buttons_ignored", o(3'b000, 3'b101, 2'd1, 3'b000));
`ifdef SOS_LATCH_EN
        tick(NONE);
        check("t5_latched", o(3'b000, 3'b101, 2'd1, 3'b000));
        ticks(3);
        check("t5_still_latched", o(3'b000, 3'b101, 2'd1, 3'b000));
`else
        tick(NONE);
        check("t5_exit_idle", o(3'b000, 3'b000, 2'd1, 3'b000));
        tick(NONE);
        check("t5_stay_idle", o(3'b000, 3'b000, 2'd1, 3'b000));
`endif
        do_reset("t5_reset");

        // test 6: bidirectional requests at floor 1 follow last_dir = down
        tick(RD);
        ticks(6);
        check("t6_at_f2", o(3'b000, 3'b000, 2'd2, 3'b100));
        ticks(2);
        tick(ND);
        check("t6_down_f2", o(3'b010, 3'b000, 2'd2, 3'b001));
        ticks(3);
        ticks(2);
        check("t6_idle_f1", o(3'b000, 3'b000, 2'd1, 3'b000));
        tick(ST | RD);
        check("t6_pick_down", o(3'b101, 3'b000, 2'd1, 3'b001));
        ticks(3);
        check("t6_door_f0", o(3'b001, 3'b000, 2'd0, 3'b100));
        ticks(2);
        check("t6_then_up", o(3'b001, 3'b000, 2'd0, 3'b010));
        ticks(3);
        check("t6_pass_f1", o(3'b001, 3'b000, 2'd1, 3'b010));
        ticks(3);
        check("t6_door_f2", o(3'b000, 3'b000, 2'd2, 3'b100));
        ticks(2);
        check("t6_idle_f2", o(3'b000, 3'b000, 2'd2, 3'b000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_controller.md
Name: elevator_controller

Overview:
- Sequencing FSM for the three-floor elevator.
- Runs on the divided clock `clk` produced by the top-level frequency divisor, nominally 1 Hz.
- Latches hall/cab requests and schedules travel using direction-preserving (SCAN) order.
- Times travel and door dwell; handles the overweight hold and the SOS emergency.
- Drives the floor, sos, weight and emergency LEDs plus position and motion status.

Parameters:
- TRAVEL_TICKS, 3: clk cycles to move one floor; legal range >= 1.
- DOOR_TICKS, 2: clk cycles the door stays open per stop; legal range >= 1.

Ports:
- clk  input  1  divided system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sos_button  input  1  emergency request, level-sensitive.
- weight_sensor  input  1  high means the cabin is overloaded.
- st_floor_button  input  1  request for floor 0.
- nd_floor_button  input  1  request for floor 1.
- rd_floor_button  input  1  request for floor 2.
- st_floor_led  output  1  pending request at floor 0.
- nd_floor_led  output  1  pending request at floor 1.
- rd_floor_led  output  1  pending request at floor 2.
- sos_led  output  1  registered copy of sos_button.
- weight_led  output  1  registered copy of weight_sensor.
- emergency_led  output  1  high while the FSM is in EMERGENCY.
- current_floor  output  2  cabin position, 0..2; the value 3 never appears.
- door_open  output  1  high while the FSM is in DOOR_OPEN.
- moving_up  output  1  high while the FSM is in MOVE_UP.
- moving_down  output  1  high while the FSM is in MOVE_DOWN.

Behaviour:
- Reset values: state=IDLE, current_floor=0, req[2:0]=0, timer=0, last_dir=up; all LED and status outputs 0.
- Priority: reset overrides everything; sos_button overrides every other event.
- Request latch: req[i] is set on any cycle with button i high, outside EMERGENCY.
- Request clear: req[i] clears on the cycle the FSM enters DOOR_OPEN at floor i; clear takes priority over a same-cycle set.
- Floor LEDs equal req[2:0].
- sos_led and weight_led are the inputs registered, with 1-cycle latency.
- IDLE:
  - Request at current_floor -> DOOR_OPEN.
  - Else any request above -> MOVE_UP; else any request below -> MOVE_DOWN.
  - If requests exist both above and below (only possible at floor 1), follow last_dir.
- MOVE_UP / MOVE_DOWN:
  - Timer counts 0..TRAVEL_TICKS-1.
  - At terminal count, current_floor increments/decrements, timer resets to 0, last_dir is updated.
  - If req at the new floor -> DOOR_OPEN.
  - Else if requests remain further in the same direction -> stay in the move state.
  - Else -> IDLE, which re-evaluates on the next cycle.
  - The move state is never entered toward a floor beyond 0..2.
- DOOR_OPEN:
  - Timer counts 0..DOOR_TICKS-1.
  - At terminal count with weight_sensor high: timer reloads to 0 and the FSM stays (overweight hold, unbounded).
  - At terminal count with weight_sensor low: apply the same scheduling as IDLE, with last_dir preferred.
  - If no requests remain -> IDLE.
  - A new request at the current floor while the door is open is cleared immediately, with no extra dwell.
- EMERGENCY:
  - Entered the cycle after sos_button is sampled high, from any state.
  - On entry: travel aborts, the timer clears, req clears, and current_floor holds its last committed floor.
  - While in EMERGENCY: door_open=0, motion outputs 0, buttons ignored.
  - Exit condition depends on SOS_LATCH_EN (see Optional Feature).
- Reset mid-travel returns the cabin to floor 0 instantly. This is a logical state only; no physical travel is modelled.

Optional Feature:
- Macro name: SOS_LATCH_EN.
- Defined: EMERGENCY is sticky and is left only by reset. sos_led also latches high until reset.
- Undefined: EMERGENCY -> IDLE on the first cycle sos_button is sampled low; sos_led follows the registered input.

Test Plan (TRAVEL_TICKS=3, DOOR_TICKS=2):
1. Reset, then pulse rd_floor_button for 1 cycle.
   - rd_floor_led=1 and moving_up=1 from the next cycle.
   - current_floor=1 after 3 cycles, then 2 after 3 more cycles.
   - door_open=1 for 2 cycles; rd_floor_led clears on door entry; then IDLE.
2. At floor 0, press st_floor_button -> door_open=1 on the next cycle for 2 cycles; no motion occurs.
3. Moving up from floor 0 to 2, press nd_floor_button during the first travel tick.
   - Cabin stops at floor 1 with door_open=1 for 2 cycles, then resumes moving_up to floor 2.
4. Door open at floor 1 with weight_sensor held high and rd pending.
   - door_open stays 1 and weight_led=1 for 10+ cycles.
   - After weight_sensor drops, the door closes within 2 cycles, then moving_up=1.
5. Mid-travel between floors 1 and 2, assert sos_button.
   - Next cycle: emergency_led=1, moving_up=0, current_floor=1, all floor LEDs 0.
   - Without SOS_LATCH_EN: drop sos -> IDLE the next cycle.
   - With SOS_LATCH_EN: emergency_led stays 1 until reset.
6. At floor 1, idle with last_dir=down, press st_floor_button and rd_floor_button in the same cycle.
   - moving_down=1 first; floor 0 is serviced, then the cabin travels to floor 2.
